// File: rtl/adaptive_route_unit.sv
// Registered west-first/north-south adaptive route computation with credit-based selection.
// Optional: define RC_STALL_TIMEOUT_EN to abort a stalled request after STALL_LIMIT cycles.
module adaptive_route_unit #(
    parameter int COORD_WIDTH  = 4,
    parameter int CREDIT_WIDTH = 3,
    parameter int STALL_LIMIT  = 16
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [2*COORD_WIDTH-1:0]    local_in,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [2*COORD_WIDTH-1:0]    src_in,
    input  logic [2*COORD_WIDTH-1:0]    dst_in,
    input  logic [7*CREDIT_WIDTH-1:0]   credits_in,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [6:0]                  result,
    output logic                        success
);
    localparam int AW = 2 * COORD_WIDTH;
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_WAIT, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [COORD_WIDTH-1:0]  r_src_x;
    logic [AW-1:0]           r_dst;
    logic [SW-1:0]           r_stall;
    logic                    r_req_ready;
    logic                    r_resp_valid;
    logic [6:0]              r_result;
    logic                    r_success;
    logic                    w_req_ready_nxt;
    logic                    w_resp_valid_nxt;
    logic [6:0]              w_result_nxt;
    logic                    w_success_nxt;

    logic [COORD_WIDTH-1:0]  w_lx, w_ly, w_dx, w_dy;
    logic [2:0]              w_h_idx, w_v_idx;
    logic                    w_has_h, w_is_local;
    logic [CREDIT_WIDTH-1:0] w_cred_h, w_cred_v;
    logic                    w_h_ok, w_v_ok, w_pick_h, w_ok;
    logic [6:0]              w_sel;
    logic                    w_timeout;

    assign w_lx = local_in[COORD_WIDTH-1:0];
    assign w_ly = local_in[AW-1:COORD_WIDTH];
    assign w_dx = r_dst[COORD_WIDTH-1:0];
    assign w_dy = r_dst[AW-1:COORD_WIDTH];

    // V holds the only candidate for non-diagonal routes; H is used only when diagonal.
    always_comb begin
        w_is_local = 1'b0;
        w_has_h    = 1'b0;
        w_h_idx    = (w_lx > w_dx) ? 3'd5 : 3'd6;
        if (w_dy < w_ly)
            w_v_idx = (r_src_x < w_dx) ? 3'd1 : 3'd2;
        else
            w_v_idx = (r_src_x < w_dx) ? 3'd3 : 3'd4;
        if (r_dst == local_in) begin
            w_is_local = 1'b1;
            w_v_idx    = 3'd0;
        end else if (w_dx == w_lx) begin
            w_has_h = 1'b0;
        end else if (w_dy == w_ly) begin
            w_v_idx = w_h_idx;
        end else begin
            w_has_h = 1'b1;
        end
    end

    assign w_cred_h = credits_in[int'(w_h_idx)*CREDIT_WIDTH +: CREDIT_WIDTH];
    assign w_cred_v = credits_in[int'(w_v_idx)*CREDIT_WIDTH +: CREDIT_WIDTH];
    assign w_h_ok   = w_has_h && (w_cred_h != '0);
    assign w_v_ok   = w_is_local || (w_cred_v != '0);
    assign w_pick_h = w_h_ok && (!w_v_ok || (w_cred_h > w_cred_v));
    assign w_ok     = w_h_ok || w_v_ok;
    assign w_sel    = w_pick_h ? (7'b1 << w_h_idx) : (7'b1 << w_v_idx);

`ifdef RC_STALL_TIMEOUT_EN
    assign w_timeout = (r_state == S_WAIT) && !w_ok &&
                       (r_stall == SW'(STALL_LIMIT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_result     <= '0;
            r_success    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_result     <= w_result_nxt;
            r_success    <= w_success_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_state_nxt = S_EVAL;
            S_EVAL: w_state_nxt = w_ok ? S_DONE : S_WAIT;
            S_WAIT: if (w_ok || w_timeout) w_state_nxt = S_DONE;
            S_DONE: if (resp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready_nxt  = (w_state_nxt == S_IDLE);
        w_resp_valid_nxt = (w_state_nxt == S_DONE);
        w_result_nxt     = r_result;
        w_success_nxt    = r_success;
        if (r_state != S_DONE && w_state_nxt == S_DONE) begin
            w_result_nxt  = w_timeout ? 7'b0 : w_sel;
            w_success_nxt = !w_timeout;
        end else if (w_state_nxt == S_IDLE) begin
            w_result_nxt  = '0;
            w_success_nxt = 1'b0;
        end
    end

    // Only the source X coordinate influences the north/south lane choice.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_src_x <= '0;
            r_dst   <= '0;
            r_stall <= '0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_src_x <= src_in[COORD_WIDTH-1:0];
                r_dst   <= dst_in;
            end
            if (r_state == S_EVAL)
                r_stall <= '0;
            else if (r_state == S_WAIT && r_stall != '1)
                r_stall <= r_stall + 1'b1;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign result     = r_result;
    assign success    = r_success;
endmodule

// File: tb/tb_adaptive_route_unit.sv
// Directed self-checking bench for adaptive_route_unit.
// Expected values are hand-computed for local address 0x22.
module tb_adaptive_route_unit;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [7:0]  local_in = 8'h22;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  src_in = 8'h00;
    logic [7:0]  dst_in = 8'h00;
    logic [20:0] credits_in = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [6:0]  result;
    logic        success;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    adaptive_route_unit #(
        .COORD_WIDTH(4),
        .CREDIT_WIDTH(3),
        .STALL_LIMIT(8)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .local_in(local_in),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .src_in(src_in),
        .dst_in(dst_in),
        .credits_in(credits_in),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .result(result),
        .success(success)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic all_cred(input logic [2:0] v);
        for (int k = 0; k < 7; k++) credits_in[k*3 +: 3] = v;
    endtask

    task automatic set_cred(input int ch, input logic [2:0] v);
        credits_in[ch*3 +: 3] = v;
    endtask

    task automatic issue(input logic [7:0] s, input logic [7:0] d);
        req_valid = 1'b1;
        src_in = s;
        dst_in = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 RST_N = 1'b0;
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp_valid: got %b expected 0", resp_valid);
        end
        checks++;
        if (result !== 7'b0) begin
            errors++;
            $display("FAIL reset_result: got %b expected 0000000", result);
        end
        checks++;
        if (success !== 1'b0) begin
            errors++;
            $display("FAIL reset_success: got %b expected 0", success);
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_local();
        all_cred(3'd3);
        issue(8'h00, 8'h22);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL local_eval: valid=%b ready=%b expected 0 0",
                     resp_valid, req_ready);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b1 || result !== 7'b0000001 || success !== 1'b1) begin
            errors++;
            $display("FAIL local_resp: valid=%b result=%b success=%b expected 1 0000001 1",
                     resp_valid, result, success);
        end
        release_resp();
        checks++;
        if (resp_valid !== 1'b0 || result !== 7'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL local_release: valid=%b result=%b ready=%b expected 0 0000000 1",
                     resp_valid, result, req_ready);
        end
        all_cred(3'd0);
        issue(8'h00, 8'h22);
        tick();
        checks++;
        if (resp_valid !== 1'b1 || result !== 7'b0000001 || success !== 1'b1) begin
            errors++;
            $display("FAIL local_nocredit: valid=%b result=%b success=%b expected 1 0000001 1",
                     resp_valid, result, success);
        end
        release_resp();
        all_cred(3'd3);
    endtask

    task automatic test_north();
        logic [7:0] srcs [2] = '{8'h21, 8'h23};
        logic [6:0] exps [2] = '{7'b0000010, 7'b0000100};
        for (int i = 0; i < 2; i++) begin
            all_cred(3'd3);
            issue(srcs[i], 8'h02);
            tick();
            checks++;
            if (resp_valid !== 1'b1 || result !== exps[i]) begin
                errors++;
                $display("FAIL north_%0d: valid=%b result=%b expected 1 %b",
                         i, resp_valid, result, exps[i]);
            end
            release_resp();
        end
    endtask

    task automatic test_diagonal();
        logic [2:0] c5s  [4] = '{3'd4, 3'd5, 3'd1, 3'd2};
        logic [2:0] c2s  [4] = '{3'd4, 3'd4, 3'd0, 3'd7};
        logic [6:0] exps [4] = '{7'b0000100, 7'b0100000, 7'b0100000, 7'b0000100};
        for (int i = 0; i < 4; i++) begin
            all_cred(3'd3);
            set_cred(5, c5s[i]);
            set_cred(2, c2s[i]);
            issue(8'h30, 8'h00);
            tick();
            checks++;
            if (resp_valid !== 1'b1 || result !== exps[i] || success !== 1'b1) begin
                errors++;
                $display("FAIL diag_%0d: valid=%b result=%b success=%b expected 1 %b 1",
                         i, resp_valid, result, success, exps[i]);
            end
            release_resp();
        end
        all_cred(3'd3);
    endtask

    task automatic test_stall();
        all_cred(3'd3);
        set_cred(6, 3'd0);
        issue(8'h22, 8'h25);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_wait_%0d: valid=%b ready=%b expected 0 0",
                         i, resp_valid, req_ready);
            end
        end
        set_cred(6, 3'd2);
        tick();
        checks++;
        if (resp_valid !== 1'b1 || result !== 7'b1000000 || success !== 1'b1) begin
            errors++;
            $display("FAIL stall_resp: valid=%b result=%b success=%b expected 1 1000000 1",
                     resp_valid, result, success);
        end
        set_cred(6, 3'd0);
        set_cred(5, 3'd7);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b1 || result !== 7'b1000000 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: valid=%b result=%b ready=%b expected 1 1000000 0",
                         i, resp_valid, result, req_ready);
            end
        end
        release_resp();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: valid=%b ready=%b expected 0 1",
                     resp_valid, req_ready);
        end
        all_cred(3'd3);
    endtask

    task automatic test_timeout();
        all_cred(3'd3);
        set_cred(6, 3'd0);
        issue(8'h22, 8'h25);
        tick();
`ifdef RC_STALL_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early_%0d: valid=%b expected 0", i, resp_valid);
            end
        end
        tick();
        checks++;
        if (resp_valid !== 1'b1 || result !== 7'b0 || success !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: valid=%b result=%b success=%b expected 1 0000000 0",
                     resp_valid, result, success);
        end
        release_resp();
`else
        repeat (100) tick();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_forever: valid=%b ready=%b expected 0 0",
                     resp_valid, req_ready);
        end
        set_cred(6, 3'd1);
        tick();
        checks++;
        if (resp_valid !== 1'b1 || result !== 7'b1000000 || success !== 1'b1) begin
            errors++;
            $display("FAIL wait_late_credit: valid=%b result=%b success=%b expected 1 1000000 1",
                     resp_valid, result, success);
        end
        release_resp();
`endif
        all_cred(3'd3);
    endtask

    task automatic test_reset_mid_wait();
        all_cred(3'd3);
        set_cred(6, 3'd0);
        issue(8'h00, 8'h25);
        tick();
        tick();
        #3 RST_N = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || result !== 7'b0) begin
            errors++;
            $display("FAIL midwait_reset: ready=%b valid=%b result=%b expected 1 0 0000000",
                     req_ready, resp_valid, result);
        end
        tick();
        RST_N = 1'b1;
        all_cred(3'd3);
        tick();
        issue(8'h00, 8'h22);
        tick();
        checks++;
        if (resp_valid !== 1'b1 || result !== 7'b0000001 || success !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: valid=%b result=%b success=%b expected 1 0000001 1",
                     resp_valid, result, success);
        end
        release_resp();
    endtask

    initial begin
        test_reset();
        test_local();
        test_north();
        test_diagonal();
        test_stall();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
